reg_read_unit: RTL

REG_READ_UNIT -- requirements
Module: reg_read_unit

---
 rtl/reg_read_unit.sv | 139 +++++++++++++
 1 files changed

// File: rtl/reg_read_unit.sv
// Burst reader: streams burstLen+1 consecutive words (index wraps 7->0) out of an 8 x 16-bit register bank.
// Optional macro READ_PARITY_EN adds a registered even-parity output readParity.
module reg_read_unit (
  input  logic         clk,
  input  logic         reset,
  input  logic         readReq,
  input  logic [2:0]   readAddr,
  input  logic [2:0]   burstLen,
  input  logic [127:0] regBank,
  input  logic         readReady,
  output logic [15:0]  readData,
  output logic [2:0]   readIndex,
  output logic         readValid,
  output logic         busy,
  output logic         done
`ifdef READ_PARITY_EN
  ,
  output logic         readParity
`endif
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t      state_r, state_s;
  logic [15:0] data_r, data_s;
  logic [2:0]  index_r, index_s;
  logic        valid_r, valid_s;
  logic        busy_r, busy_s;
  logic        done_r, done_s;
  logic [2:0]  remaining_r, remaining_s;
  logic [2:0]  next_index_s;

  function automatic logic [15:0] bank_word(input logic [127:0] bank, input logic [2:0] idx);
    return bank[{idx, 4'd0} +: 16];
  endfunction

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state and next-value logic; the bank is only read on load edges
  always_comb begin
    state_s      = state_r;
    data_s       = data_r;
    index_s      = index_r;
    valid_s      = valid_r;
    remaining_s  = remaining_r;
    next_index_s = index_r + 3'd1;
    case (state_r)
      IDLE: begin
        if (readReq) begin
          state_s     = STREAM;
          data_s      = bank_word(regBank, readAddr);
          index_s     = readAddr;
          valid_s     = 1'b1;
          remaining_s = burstLen;
        end else begin
          state_s = IDLE;
        end
      end
      STREAM: begin
        if (valid_r && readReady) begin
          if (remaining_r != 3'd0) begin
            data_s      = bank_word(regBank, next_index_s);
            index_s     = next_index_s;
            remaining_s = remaining_r - 3'd1;
          end else begin
            valid_s = 1'b0;
            state_s = FINISH;
          end
        end else begin
          state_s = STREAM;
        end
      end
      FINISH: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
    busy_s = (state_s != IDLE);
    done_s = (state_s == FINISH);
  end

  // Output and burst-tracking registers
  always_ff @(posedge clk) begin
    if (reset) begin
      data_r      <= 16'd0;
      index_r     <= 3'd0;
      valid_r     <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      remaining_r <= 3'd0;
    end else begin
      data_r      <= data_s;
      index_r     <= index_s;
      valid_r     <= valid_s;
      busy_r      <= busy_s;
      done_r      <= done_s;
      remaining_r <= remaining_s;
    end
  end

  assign readData  = data_r;
  assign readIndex = index_r;
  assign readValid = valid_r;
  assign busy      = busy_r;
  assign done      = done_r;

`ifdef READ_PARITY_EN
  logic parity_r;

  function automatic logic parity16(input logic [15:0] word);
    return ^word;
  endfunction

  // Parity tracks data_s so it always matches the word held in readData
  always_ff @(posedge clk) begin
    if (reset) begin
      parity_r <= 1'b0;
    end else begin
      parity_r <= parity16(data_s);
    end
  end

  assign readParity = parity_r;
`endif

endmodule
